// File: rtl/color_convert_pipe.sv
// color_convert_pipe: three-lane float-to-integer colour converter with a
// credit-tracked first-word-fall-through output FIFO. Pipeline stages
// S1 classify/unpack, S2 align shift, S3 round/saturate/pack, then FIFO.
// Optional feature macro: CC_ROUND_EN selects round-to-nearest (ties up)
// instead of truncation; latency and interface are the same either way.
`timescale 1ns/1ps
module color_convert_pipe #(
   parameter int R_W        = 4,
   parameter int G_W        = 5,
   parameter int B_W        = 4,
   parameter int PID_W      = 19,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           us_valid,
   output logic                           us_stall,
   input  logic [PID_W-1:0]               us_pixelID,
   input  logic [95:0]                    us_color,
   output logic                           ds_valid,
   input  logic                           ds_stall,
   output logic [PID_W+R_W+G_W+B_W-1:0]   ds_data
);

   localparam int CW = R_W + G_W + B_W;
   localparam int DW = PID_W + CW;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int OW = $clog2(FIFO_DEPTH + 1);
`ifdef CC_ROUND_EN
   localparam logic [40:0] RND_ADD = 41'd8388608;   // half of the 2^24 output step
`else
   localparam logic [40:0] RND_ADD = 41'd0;
`endif

   logic [OW-1:0]    occ_reg, occ_next;
   logic             accept, pop;
   logic             s1_valid_reg, s2_valid_reg, s3_valid_reg;
   logic [PID_W-1:0] s1_pid_reg, s2_pid_reg, s3_pid_reg;
   logic [CW-1:0]    lane_bus;
   logic [DW-1:0]    mem [FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr_reg, rd_ptr_reg;
   logic [OW-1:0]    cnt_reg;

   // Credits count everything accepted but not yet popped, so the FIFO
   // always has room for whatever is still travelling down the pipeline.
   assign us_stall = (occ_reg >= OW'(FIFO_DEPTH));
   assign accept   = us_valid && !us_stall;
   assign pop      = ds_valid && !ds_stall;

   // Occupancy next-state: +1 on accept, -1 on pop, unchanged on both.
   always_comb begin
      occ_next = occ_reg;
      if (accept && !pop)
         occ_next = occ_reg + 1'b1;
      else if (!accept && pop)
         occ_next = occ_reg - 1'b1;
   end

   // Occupancy register.
   always_ff @(posedge clk) begin
      if (!rst) occ_reg <= '0;
      else      occ_reg <= occ_next;
   end

   // Valid and pixelID travel alongside the lanes; no stage ever stalls.
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
         s3_valid_reg <= 1'b0;
         s1_pid_reg   <= '0;
         s2_pid_reg   <= '0;
         s3_pid_reg   <= '0;
      end else begin
         s1_valid_reg <= accept;
         s2_valid_reg <= s1_valid_reg;
         s3_valid_reg <= s2_valid_reg;
         s1_pid_reg   <= us_pixelID;
         s2_pid_reg   <= s1_pid_reg;
         s3_pid_reg   <= s2_pid_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_lane
         localparam int W   = (gi == 0) ? R_W : ((gi == 1) ? G_W : B_W);
         localparam int OFF = (gi == 0) ? (G_W + B_W) : ((gi == 1) ? B_W : 0);
         localparam logic [16:0] MAXV = 17'((1 << W) - 1);

         logic [31:0]  f;
         int           sh_c;
         logic         s1_zero_next, s1_sat_next;
         logic [4:0]   s1_shamt_next;
         logic         s1_zero_reg, s1_sat_reg;
         logic [23:0]  s1_mant_reg;
         logic [4:0]   s1_shamt_reg;
         logic         s2_zero_reg, s2_sat_reg;
         logic [39:0]  s2_shifted_reg;
         logic [16:0]  s3_q;
         logic [W-1:0] s3_val_next, s3_val_reg;

         assign f = us_color[95-32*gi -: 32];

         // S1: classify specials and work out the alignment shift. The shift
         // is kept as sh+1 so the sh==-1 rounding case stays an integer shift.
         always_comb begin
            s1_zero_next  = 1'b0;
            s1_sat_next   = 1'b0;
            s1_shamt_next = '0;
            sh_c          = int'(f[30:23]) - 127 + W;
            if (f[30:23] == 8'hFF && f[22:0] != '0)
               s1_zero_next = 1'b1;
            else if (f[31])
               s1_zero_next = 1'b1;
            else if (f[30:23] == 8'd0)
               s1_zero_next = 1'b1;
            else if (f[30:23] >= 8'd127)
               s1_sat_next = 1'b1;
            else if (sh_c < -1)
               s1_zero_next = 1'b1;
            else
               s1_shamt_next = 5'(sh_c + 1);
         end

         // S1 register: flags plus the mantissa with its hidden one.
         always_ff @(posedge clk) begin
            if (!rst) begin
               s1_zero_reg  <= 1'b0;
               s1_sat_reg   <= 1'b0;
               s1_mant_reg  <= '0;
               s1_shamt_reg <= '0;
            end else begin
               s1_zero_reg  <= s1_zero_next;
               s1_sat_reg   <= s1_sat_next;
               s1_mant_reg  <= {1'b1, f[22:0]};
               s1_shamt_reg <= s1_shamt_next;
            end
         end

         // S2: full-width left shift, binary point ends up at bit 24.
         always_ff @(posedge clk) begin
            if (!rst) begin
               s2_zero_reg    <= 1'b0;
               s2_sat_reg     <= 1'b0;
               s2_shifted_reg <= '0;
            end else begin
               s2_zero_reg    <= s1_zero_reg;
               s2_sat_reg     <= s1_sat_reg;
               s2_shifted_reg <= {16'd0, s1_mant_reg} << s1_shamt_reg;
            end
         end

         // S3 combinational: optional half-step add, floor, then saturate.
         always_comb begin
            s3_q        = 17'(({1'b0, s2_shifted_reg} + RND_ADD) >> 24);
            s3_val_next = s3_q[W-1:0];
            if (s2_zero_reg)
               s3_val_next = '0;
            else if (s2_sat_reg || s3_q > MAXV)
               s3_val_next = MAXV[W-1:0];
         end

         // S3 register feeding the FIFO write port.
         always_ff @(posedge clk) begin
            if (!rst) s3_val_reg <= '0;
            else      s3_val_reg <= s3_val_next;
         end

         assign lane_bus[OFF +: W] = s3_val_reg;
      end
   endgenerate

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // FIFO storage; written by S3 every cycle it holds a valid entry.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else if (s3_valid_reg) begin
         mem[wr_ptr_reg] <= {s3_pid_reg, lane_bus};
      end
   end

   // FIFO pointers and fill count.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         cnt_reg    <= '0;
      end else begin
         if (s3_valid_reg) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
         if (pop)          rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         if (s3_valid_reg && !pop)
            cnt_reg <= cnt_reg + 1'b1;
         else if (!s3_valid_reg && pop)
            cnt_reg <= cnt_reg - 1'b1;
      end
   end

   // Head is presented directly; a write into an empty FIFO shows next cycle.
   assign ds_valid = (cnt_reg != '0);
   assign ds_data  = mem[rd_ptr_reg];

   // Credits must make a write into a full FIFO impossible.
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(s3_valid_reg && cnt_reg == OW'(FIFO_DEPTH)));

endmodule
